// File: rtl/uart_mem_loader_pkg.sv
// rtl/uart_mem_loader_pkg.sv - shared FSM states and UART frame constants (CHECK state present only with LOADER_CHECKSUM_EN)
package uart_mem_loader_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    LOAD,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    IDLE,
    SCAN_RD,
    SCAN_TX
  } loader_state_e;

endpackage

// File: rtl/uart_mem_loader_if.sv
// rtl/uart_mem_loader_if.sv - RAM access bus between the loader (master) and the RAM (slave)
interface uart_mem_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);

  logic [DATA_W-1:0] ram_out;
  logic              ram_rw;
  logic              ram_enable;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_in;

  modport master (
    input  ram_out,
    output ram_rw,
    output ram_enable,
    output ram_adr,
    output ram_in
  );

  modport slave (
    output ram_out,
    input  ram_rw,
    input  ram_enable,
    input  ram_adr,
    input  ram_in
  );

endinterface

// File: rtl/uart_phy.sv
// rtl/uart_phy.sv - 8N1 UART bit engine: rx synchroniser/sampler, tx shifter, ce-gated baud counters
module uart_phy
  import uart_mem_loader_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_tdata,
  output logic       rx_tvalid,
  output logic       rx_ferr,
  input  logic [7:0] tx_tdata,
  input  logic       tx_tvalid,
  output logic       tx_tready
);

  localparam int               CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [3:0]       DATA_END = 4'(UART_DATA_BITS);
  localparam logic [3:0]       STOP_POS = 4'(UART_DATA_BITS + 1);

  logic             rx_meta, rx_sync, rx_prev, rx_busy;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_shift;

  logic             tx_busy;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [7:0]       tx_shift;

  // A new byte is taken when idle or in the very last cycle of the stop bit, so frames run back to back.
  assign tx_tready = ce && (!tx_busy || (tx_cnt == '0 && tx_bit == STOP_POS));

  // Receiver: two-flop synchroniser, falling-edge start detect, mid-bit sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_busy   <= 1'b0;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_tdata  <= '0;
      rx_tvalid <= 1'b0;
      rx_ferr   <= 1'b0;
    end else if (ce) begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_tvalid <= 1'b0;
      rx_ferr   <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_sync) begin
          rx_busy <= 1'b1;
          rx_cnt  <= CNT_HALF;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= CNT_FULL;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == '0) begin
          // A start bit that is high again at mid-bit was a glitch.
          if (rx_sync != UART_START_BIT) rx_busy <= 1'b0;
        end else if (rx_bit == STOP_POS) begin
          rx_busy <= 1'b0;
          if (rx_sync == UART_STOP_BIT) begin
            rx_tdata  <= rx_shift;
            rx_tvalid <= 1'b1;
          end else begin
            rx_ferr <= 1'b1;
          end
        end else begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
        end
      end
    end
  end

  // Transmitter: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= UART_STOP_BIT;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (ce) begin
      if (tx_tvalid && tx_tready) begin
        tx       <= UART_START_BIT;
        tx_shift <= tx_tdata;
        tx_cnt   <= CNT_FULL;
        tx_bit   <= '0;
        tx_busy  <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt != '0) begin
          tx_cnt <= tx_cnt - 1'b1;
        end else if (tx_bit == STOP_POS) begin
          tx_busy <= 1'b0;
        end else begin
          tx_cnt <= CNT_FULL;
          tx_bit <= tx_bit + 4'd1;
          if (tx_bit == DATA_END) begin
            tx <= UART_STOP_BIT;
          end else begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - loads a RAM image from UART and dumps it back on request (LOADER_CHECKSUM_EN adds a trailing XOR check)
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6,
  parameter int CLK_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             rx,
  output logic             tx,
  input  logic             scan_memory,
  output logic             boot,
  output logic             err,
  uart_mem_loader_if.master ram
);

  localparam int               BYTES     = DATA_W / 8;
  localparam int               BC_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0]  BYTE_LAST = BC_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] ADR_LAST = '1;

  loader_state_e     state;
  logic [ADDR_W-1:0] addr;
  logic [BC_W-1:0]   byte_cnt;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_in;
  logic [DATA_W-1:0] word_shl;
  logic              scan_prev;
  logic              rd_wait;
  logic [7:0]        tx_tdata;
  logic              tx_tvalid;
  logic              tx_tready;
  logic [7:0]        rx_tdata;
  logic              rx_tvalid;
  logic              rx_ferr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // Bytes arrive MSB first, so each new byte shifts the word up.
  assign word_in  = (word << 8) | DATA_W'(rx_tdata);
  assign word_shl = word << 8;

  uart_phy #(
    .CLK_DIV (CLK_DIV)
  ) u_phy (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .rx        (rx),
    .tx        (tx),
    .rx_tdata  (rx_tdata),
    .rx_tvalid (rx_tvalid),
    .rx_ferr   (rx_ferr),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready)
  );

  // Loader/scanner FSM with registered RAM strobes and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LOAD;
      addr           <= '0;
      byte_cnt       <= '0;
      word           <= '0;
      scan_prev      <= 1'b0;
      rd_wait        <= 1'b0;
      tx_tdata       <= '0;
      tx_tvalid      <= 1'b0;
      boot           <= 1'b1;
      err            <= 1'b0;
      ram.ram_enable <= 1'b0;
      ram.ram_rw     <= 1'b0;
      ram.ram_adr    <= '0;
      ram.ram_in     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else if (ce) begin
      scan_prev <= scan_memory;
      case (state)
        LOAD: begin
          // A framing error drops the byte but leaves the byte position untouched.
          if (rx_ferr) begin
            err <= 1'b1;
          end else if (rx_tvalid) begin
            word <= word_in;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_tdata;
`endif
            if (byte_cnt == BYTE_LAST) begin
              byte_cnt       <= '0;
              state          <= WRITE;
              ram.ram_enable <= 1'b1;
              ram.ram_rw     <= 1'b1;
              ram.ram_adr    <= addr;
              ram.ram_in     <= word_in;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          ram.ram_enable <= 1'b0;
          ram.ram_rw     <= 1'b0;
          if (addr == ADR_LAST) begin
            addr <= '0;
`ifdef LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state <= IDLE;
            boot  <= 1'b0;
`endif
          end else begin
            addr  <= addr + 1'b1;
            state <= LOAD;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_ferr) begin
            err <= 1'b1;
          end else if (rx_tvalid) begin
            if (rx_tdata != csum) err <= 1'b1;
            state <= IDLE;
            boot  <= 1'b0;
          end
        end
`endif
        IDLE: begin
          if (scan_memory && !scan_prev) begin
            state          <= SCAN_RD;
            addr           <= '0;
            rd_wait        <= 1'b0;
            ram.ram_enable <= 1'b1;
            ram.ram_rw     <= 1'b0;
            ram.ram_adr    <= '0;
          end
        end
        SCAN_RD: begin
          // First cycle carries the read strobe, second cycle captures the read data.
          if (!rd_wait) begin
            ram.ram_enable <= 1'b0;
            rd_wait        <= 1'b1;
          end else begin
            rd_wait   <= 1'b0;
            word      <= ram.ram_out;
            tx_tdata  <= ram.ram_out[DATA_W-1 -: 8];
            tx_tvalid <= 1'b1;
            byte_cnt  <= '0;
            state     <= SCAN_TX;
          end
        end
        SCAN_TX: begin
          if (tx_tvalid && tx_tready) begin
            if (byte_cnt == BYTE_LAST) begin
              tx_tvalid <= 1'b0;
              byte_cnt  <= '0;
              if (addr == ADR_LAST) begin
                addr  <= '0;
                state <= IDLE;
              end else begin
                // Prefetch the next word while the last byte is still on the wire.
                addr           <= addr + 1'b1;
                ram.ram_adr    <= addr + 1'b1;
                ram.ram_enable <= 1'b1;
                ram.ram_rw     <= 1'b0;
                state          <= SCAN_RD;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              word     <= word_shl;
              tx_tdata <= word_shl[DATA_W-1 -: 8];
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - directed bench for uart_mem_loader (expectations follow LOADER_CHECKSUM_EN)
module tb_uart_mem_loader;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 6;
  localparam int CLK_DIV = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam logic CSUM_ON = 1'b1;
`else
  localparam logic CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  logic rx;
  logic tx;
  logic scan_memory;
  logic boot;
  logic err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  int                wr_cnt;
  logic [ADDR_W-1:0] first_adr;
  logic [DATA_W-1:0] first_data;

  logic [7:0] tx_q [$];
  logic [7:0] mon_byte;
  int         mon_stop_err = 0;

  uart_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram_bus ();

  uart_mem_loader #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .rx          (rx),
    .tx          (tx),
    .scan_memory (scan_memory),
    .boot        (boot),
    .err         (err),
    .ram         (ram_bus)
  );

  always #5 clk = ~clk;

  // RAM model: clears on reset, logs writes, read data one cycle after the strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      wr_cnt          <= 0;
      first_adr       <= '1;
      first_data      <= '0;
      ram_bus.ram_out <= '0;
    end else if (ce && ram_bus.ram_enable) begin
      if (ram_bus.ram_rw) begin
        mem[ram_bus.ram_adr] <= ram_bus.ram_in;
        wr_cnt <= wr_cnt + 1;
        if (wr_cnt == 0) begin
          first_adr  <= ram_bus.ram_adr;
          first_data <= ram_bus.ram_in;
        end
      end else begin
        ram_bus.ram_out <= mem[ram_bus.ram_adr];
      end
    end
  end

  // Serial decoder for tx, sampling mid-bit.
  initial begin
    @(posedge rst_n);
    forever begin
      @(negedge tx);
      repeat (CLK_DIV / 2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(posedge clk);
        #1;
        mon_byte[i] = tx;
      end
      repeat (CLK_DIV) @(posedge clk);
      #1;
      if (tx !== 1'b1) mon_stop_err++;
      tx_q.push_back(mon_byte);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int pause_bit, input int exp_wr);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == pause_bit) begin
        ce = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("ce_pause_writes", wr_cnt, exp_wr);
        check_eq("ce_pause_boot", boot, 1);
        ce = 1'b1;
      end
      rx = f[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    if (!stop) begin
      rx = 1'b1;
      repeat (CLK_DIV) @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_tx"}, tx, 1);
    check_eq({pfx, "_boot"}, boot, 1);
    check_eq({pfx, "_ram_enable"}, ram_bus.ram_enable, 0);
    check_eq({pfx, "_ram_rw"}, ram_bus.ram_rw, 0);
    check_eq({pfx, "_ram_adr"}, ram_bus.ram_adr, 0);
    check_eq({pfx, "_ram_in"}, ram_bus.ram_in, 0);
    check_eq({pfx, "_err"}, err, 0);
  endtask

  initial begin
    int cyc;
    ce = 1'b1;
    rx = 1'b1;
    scan_memory = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Load A: 128 ramp bytes, clock enable paused in the middle of byte 11.
    for (int b = 0; b < 128; b++) begin
      if (b == 11) send_byte(8'(b), 1'b1, 3, 5);
      else         send_byte(8'(b), 1'b1, -1, 0);
    end
    repeat (4) @(negedge clk);
    check_eq("loadA_writes", wr_cnt, 64);
    check_eq("loadA_word0", mem[0], 32'h0001);
    check_eq("loadA_word5", mem[5], 32'h0A0B);
    check_eq("loadA_word63", mem[63], 32'h7E7F);
    check_eq("loadA_boot_before_csum", boot, CSUM_ON);
    send_byte(8'h00, 1'b1, -1, 0);
    repeat (4) @(negedge clk);
    check_eq("loadA_err", err, 0);
    check_eq("loadA_boot", boot, 0);

    // Scan: the image comes back on tx in load order.
    @(negedge clk);
    scan_memory = 1'b1;
    repeat (3) @(negedge clk);
    scan_memory = 1'b0;
    cyc = 0;
    while (tx_q.size() < 128 && cyc < 22000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    check_eq("scan_count", tx_q.size(), 128);
    for (int i = 0; i < 128 && i < tx_q.size(); i++)
      check_eq($sformatf("scan_byte%0d", i), tx_q[i], i);
    check_eq("scan_stop_bits", mon_stop_err, 0);
    check_eq("scan_tx_idle", tx, 1);
    check_eq("scan_boot", boot, 0);
    check_eq("scan_ram_enable", ram_bus.ram_enable, 0);

    // Partial load with a framing error at byte position 1 of word 10.
    pulse_reset();
    for (int b = 0; b < 74; b++) begin
      send_byte(8'(b), 1'b1, -1, 0);
      if (b == 20) begin
        send_byte(8'h55, 1'b0, -1, 0);
        repeat (4) @(negedge clk);
        check_eq("ferr_err", err, 1);
        check_eq("ferr_no_write", wr_cnt, 10);
      end
    end
    repeat (4) @(negedge clk);
    check_eq("part_writes", wr_cnt, 37);
    check_eq("part_word10", mem[10], 32'h1415);
    check_eq("part_word36", mem[36], 32'h4849);
    send_byte(8'd74, 1'b1, -1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Load B from scratch, then a wrong trailer byte.
    for (int b = 0; b < 128; b++) send_byte(8'(b), 1'b1, -1, 0);
    repeat (4) @(negedge clk);
    check_eq("loadB_writes", wr_cnt, 64);
    check_eq("loadB_first_adr", first_adr, 0);
    check_eq("loadB_first_data", first_data, 32'h0001);
    check_eq("loadB_word63", mem[63], 32'h7E7F);
    send_byte(8'h5A, 1'b1, -1, 0);
    repeat (4) @(negedge clk);
    check_eq("loadB_err", err, CSUM_ON);
    check_eq("loadB_boot", boot, 0);
    check_eq("loadB_no_extra_write", wr_cnt, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
